smol_fetch: RTL
===============

# smol_fetch

Instruction fetch stage sitting directly upstream of the synchronous-read instruction ROM (`SYNC_READ=1`, one-cycle read latency). It owns the program counter and drives the ROM byte address. It pairs each returned instruction word with its PC and presents it to decode over a valid/ready handshake. A one-entry skid buffer absorbs decode back-pressure without losing or duplicating instructions, and a redirect port (branch/jump/trap) flushes in-flight work.

## Interface

- `ADDR_WIDTH`, 10, ROM word-address bits; the PC is `ADDR_WIDTH+2` bits wide (byte address).
- `DATA_WIDTH`, 32, instruction width.
- `RESET_PC`, 0, byte address fetched first after reset; bits [1:0] must be 0.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `imem_addr`  out  ADDR_WIDTH+2  byte address to ROM; registered output.
- `imem_data`  in  DATA_WIDTH  ROM data, equal to mem[`imem_addr` sampled at previous edge].
- `redirect_valid`  in  1  load new PC this cycle.
- `redirect_pc`  in  ADDR_WIDTH+2  target byte address; bits [1:0] are ignored (forced 0).
- `if_valid`  out  1  instruction available to decode.
- `if_ready`  in  1  decode accepts.
- `if_instr`  out  DATA_WIDTH  instruction.
- `if_pc`  out  ADDR_WIDTH+2  byte address of `if_instr`.

## Operation

- State: `pc_req` (drives `imem_addr`), `inf_valid`/`inf_pc` (the request whose data is on `imem_data` now), `skid_valid`/`skid_pc`/`skid_instr`.
- Output mux: if `skid_valid`, present the skid entry. Otherwise present `{inf_valid, inf_pc, imem_data}`.
- Each edge without redirect: `inf_pc <= pc_req`, `inf_valid <= 1`.
- Transfer = `if_valid & if_ready`.
- Skid empty, transfer: skid stays empty; `pc_req <= pc_req + 4`.
- Skid empty, `inf_valid` and no transfer: skid captures the inflight entry; `pc_req` holds.
- Skid full, transfer: skid empties; `pc_req <= pc_req + 4`.
- Skid full, no transfer: all state holds.
- While `pc_req` holds, the ROM re-reads the same address. The refreshed inflight entry is identical, so no duplicate is ever emitted.
- Redirect (priority over everything):
  - `pc_req <= {redirect_pc[ADDR_WIDTH+1:2], 2'b00}`; `inf_valid <= 0`; `skid_valid <= 0`.
  - A transfer in the same cycle still completes from decode's point of view; the instruction after it is discarded.
- PC arithmetic is modulo 2^(ADDR_WIDTH+2). `pc_req` wraps from the top word to 0 silently.
- Outputs are stable while `if_valid & !if_ready`: `if_instr`/`if_pc` must not change until transfer or redirect.

## Timing

- Reset values: `pc_req=RESET_PC` (so `imem_addr=RESET_PC`), `inf_valid=0`, `skid_valid=0`, `if_valid=0`; `if_instr`/`if_pc` don't-care while invalid.
- After `rst` deasserts, `if_valid` rises the cycle after the first edge, carrying `RESET_PC`.
- Throughput is one instruction per cycle when `if_ready` stays high.
- Redirect penalty: redirect in cycle N, so `imem_addr`=target in N+1 and `if_valid` with `if_pc`=target in N+2. `if_valid` is 0 in N+1.
- After a stall releases, instructions resume back-to-back with no bubble.
- `rst` mid-stream returns to reset state immediately (async). Any partially accepted stream is dropped.
- No combinational path from `if_ready` or `redirect_*` to `imem_addr`.

## Configuration

- `SMOL_FETCH_PERF_EN` defined: adds ports `perf_fetched` (out, 32) and `perf_stall` (out, 32).
  - `perf_fetched` counts transfers; `perf_stall` counts cycles with `if_valid & !if_ready`.
  - Both reset to 0 and wrap at 2^32.
- Undefined: ports and counters are absent; functional behaviour is identical.

## Structure

- Shared package `smol_pkg`:
  - `PC_STEP` = 4.
  - typedef `fetch_entry_t` struct `{pc, instr}` sized from `ADDR_WIDTH`/`DATA_WIDTH` defaults.
- Sub-module `smol_skid_buf` holds one `fetch_entry_t` with load/clear/valid. The PC/redirect logic stays in `smol_fetch`.

## Test plan

- Reset release with `if_ready=1`, ROM words 0..7 = 0x100+i: `if_pc` = 0,4,8,… with `if_instr` = 0x100,0x101,… on consecutive cycles, first valid one cycle after reset.
- Hold `if_ready=0` for 5 cycles at `if_pc=8`: `if_pc`/`if_instr` frozen. On release, 8, 12, 16 are delivered back-to-back with no skip and no duplicate.
- Redirect to 0x40 during streaming: exactly one invalid cycle, then `if_pc`=0x40, 0x44.
- Redirect to 0x41 while stalled with skid full: skid and inflight flushed, next `if_pc`=0x40.
- Stream past top word (`ADDR_WIDTH=3`, PC 0x1C): next `if_pc`=0x00.
- With `SMOL_FETCH_PERF_EN`, 10 transfers and 3 stall cycles: `perf_fetched`=10, `perf_stall`=3; both return to 0 on `rst`.

Source files
------------

// File: rtl/smol_pkg.sv
// Shared fetch-stage definitions: PC increment and the default-width fetch entry.
package smol_pkg;

    localparam int unsigned FE_ADDR_WIDTH = 10;
    localparam int unsigned FE_DATA_WIDTH = 32;
    localparam int unsigned PC_STEP       = 4;

    typedef struct packed {
        logic [FE_ADDR_WIDTH+1:0] pc;
        logic [FE_DATA_WIDTH-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/smol_skid_buf.sv
// One-entry holding register for a fetched {pc, instr} pair; clear wins over load.
module smol_skid_buf
    import smol_pkg::*;
#(
    parameter type entry_t = fetch_entry_t
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   i_load,
    input  logic   i_clear,
    input  entry_t i_entry,
    output logic   o_valid,
    output entry_t o_entry
);

    logic   r_valid;
    entry_t r_entry;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_entry <= '0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_entry <= i_entry;
        end
    end

    assign o_valid = r_valid;
    assign o_entry = r_entry;

endmodule

// File: rtl/smol_fetch.sv
// Instruction fetch stage in front of a one-cycle synchronous ROM, with skid buffer and redirect.
// Optional performance counters are enabled with SMOL_FETCH_PERF_EN.
module smol_fetch
    import smol_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH = 10,
    parameter int unsigned           DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH+1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [ADDR_WIDTH+1:0] imem_addr,
    input  logic [DATA_WIDTH-1:0] imem_data,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH+1:0] redirect_pc,
    output logic                  if_valid,
    input  logic                  if_ready,
    output logic [DATA_WIDTH-1:0] if_instr,
    output logic [ADDR_WIDTH+1:0] if_pc
`ifdef SMOL_FETCH_PERF_EN
    ,
    output logic [31:0]           perf_fetched,
    output logic [31:0]           perf_stall
`endif
);

    localparam int unsigned     PC_W = ADDR_WIDTH + 2;
    localparam logic [PC_W-1:0] STEP = PC_W'(PC_STEP);

    typedef struct packed {
        logic [PC_W-1:0]       pc;
        logic [DATA_WIDTH-1:0] instr;
    } entry_t;

    logic [PC_W-1:0] r_pc_req;
    logic [PC_W-1:0] r_inf_pc;
    logic            r_inf_valid;

    logic   w_skid_valid;
    entry_t w_skid_entry;
    entry_t w_inf_entry;
    logic   w_transfer;
    logic   w_advance;
    logic   w_skid_load;
    logic   w_skid_clear;
    logic   w_unused;

    assign w_unused    = ^redirect_pc[1:0];
    assign w_inf_entry = '{pc: r_inf_pc, instr: imem_data};

    assign if_valid = w_skid_valid | r_inf_valid;
    assign if_pc    = w_skid_valid ? w_skid_entry.pc    : r_inf_pc;
    assign if_instr = w_skid_valid ? w_skid_entry.instr : imem_data;

    assign w_transfer = if_valid & if_ready;
    // pc_req runs one word ahead of the inflight entry; it only stops while an entry is parked.
    assign w_advance    = w_transfer | (~w_skid_valid & ~r_inf_valid);
    assign w_skid_load  = ~w_skid_valid & r_inf_valid & ~w_transfer;
    assign w_skid_clear = redirect_valid | (w_skid_valid & w_transfer);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc_req    <= RESET_PC;
            r_inf_pc    <= RESET_PC;
            r_inf_valid <= 1'b0;
        end else if (redirect_valid) begin
            r_pc_req    <= {redirect_pc[PC_W-1:2], 2'b00};
            r_inf_valid <= 1'b0;
        end else begin
            r_inf_pc    <= r_pc_req;
            r_inf_valid <= 1'b1;
            if (w_advance) begin
                r_pc_req <= r_pc_req + STEP;
            end
        end
    end

    assign imem_addr = r_pc_req;

    smol_skid_buf #(
        .entry_t (entry_t)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_skid_load),
        .i_clear (w_skid_clear),
        .i_entry (w_inf_entry),
        .o_valid (w_skid_valid),
        .o_entry (w_skid_entry)
    );

`ifdef SMOL_FETCH_PERF_EN
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf_fetched <= '0;
            r_perf_stall   <= '0;
        end else begin
            if (w_transfer) begin
                r_perf_fetched <= r_perf_fetched + 32'd1;
            end
            if (if_valid & ~if_ready) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
        end
    end

    assign perf_fetched = r_perf_fetched;
    assign perf_stall   = r_perf_stall;
`endif

endmodule
